mem_port_arbiter: RTL

Two-port arbiter and access sequencer in front of the single-port `Mem` data memory. It accepts byte, halfword and word load/store requests from two requesters, for example the CPU data stage (port 0) and a debug/loader port (port 1). It grants them round-robin and converts byte addresses and sizes into Mem word address, `sel` lanes and replicated store data. Load data returned by Mem is shifted and extended before it goes back to the granted requester over a valid/ready response channel.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_port_arbiter_lane_fmt.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port Mem arbiter.
//   SZ_*        : request size encodings
//   arb_state_e : sequencer states
//   aw_of()     : request byte-address width from the Mem word-address width
//   access_err(): illegal size or misaligned access
package mem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StCapture,
    StResp
  } arb_state_e;

  function automatic int unsigned aw_of(input int unsigned mem_addr_bits);
    return mem_addr_bits + 2;
  endfunction

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_BAD) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_fmt.sv
// Combinational byte-lane formatter between a latched request and Mem.
//   size, addr_lo, sign_ext : latched request attributes
//   wdata                   : right-justified store data
//   mem_data_out            : sel-masked word returned by Mem
//   sel, st_data            : Mem lane enables and lane-replicated store data
//   ld_data                 : load result shifted down and extended
//   misalign                : illegal size or misaligned address
module mem_lane_fmt
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_data_out,
  output logic [3:0]  sel,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted  = mem_data_out >> {addr_lo, 3'b000};
  assign misalign = access_err(size, addr_lo);

  always_comb begin
    sel     = 4'b0000;
    st_data = 32'h0;
    ld_data = shifted;
    unique case (size)
      SZ_BYTE: begin
        sel     = 4'b0001 << addr_lo;
        st_data = {4{wdata[7:0]}};
        ld_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sel     = 4'b0011 << addr_lo;
        st_data = {2{wdata[15:0]}};
        ld_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        sel     = 4'b1111;
        st_data = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of single-port Mem.
//   clk, clr                 : clock, asynchronous active-high reset
//   req_*                    : per-port load/store requests (valid/ready)
//   rsp_*                    : response to the granted port (valid/ready), shared data/err
//   mem_*                    : Mem port; strobes only in the ACCESS cycle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter int unsigned MEM_DATA_BITS = 32,
  localparam int unsigned AW = aw_of(MEM_ADDR_BITS)
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_we,
  input  logic [3:0]                 req_size,
  input  logic [1:0]                 req_signed,
  input  logic [2*AW-1:0]            req_addr,
  input  logic [2*MEM_DATA_BITS-1:0] req_wdata,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [MEM_DATA_BITS-1:0]   rsp_rdata,
  output logic                       rsp_err,
  output logic [MEM_ADDR_BITS-1:0]   mem_addr,
  output logic [MEM_DATA_BITS-1:0]   mem_data_in,
  output logic                       mem_str,
  output logic [3:0]                 mem_sel,
  output logic                       mem_ld,
  input  logic [MEM_DATA_BITS-1:0]   mem_data_out
);

  arb_state_e state_q;
  logic       last_q, gnt_q, we_q, signed_q, err_q;
  logic [1:0] size_q;
  logic [AW-1:0] addr_q;
  logic [MEM_DATA_BITS-1:0] wdata_q, rdata_q;

  logic g, accept;
  logic [1:0] in_size;
  logic [AW-1:0] in_addr;
  logic [MEM_DATA_BITS-1:0] in_wdata;

  logic [3:0] fmt_sel;
  logic [31:0] fmt_st_data, fmt_ld_data;
  logic fmt_misalign;

  // Single requester wins outright; on a tie (or no request) the port not served last.
  always_comb begin
    case (req_valid)
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
      default: g = ~last_q;
    endcase
  end

  assign req_ready = (state_q == StIdle && !clr) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = (state_q == StIdle) && req_valid[g];

  assign in_size  = g ? req_size[3:2] : req_size[1:0];
  assign in_addr  = g ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign in_wdata = g ? req_wdata[2*MEM_DATA_BITS-1:MEM_DATA_BITS]
                      : req_wdata[MEM_DATA_BITS-1:0];

  mem_lane_fmt u_fmt (
    .size         (size_q),
    .addr_lo      (addr_q[1:0]),
    .sign_ext     (signed_q),
    .wdata        (wdata_q),
    .mem_data_out (mem_data_out),
    .sel          (fmt_sel),
    .st_data      (fmt_st_data),
    .ld_data      (fmt_ld_data),
    .misalign     (fmt_misalign)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            gnt_q    <= g;
            last_q   <= g;
            we_q     <= req_we[g];
            signed_q <= req_signed[g];
            size_q   <= in_size;
            addr_q   <= in_addr;
            wdata_q  <= in_wdata;
            rdata_q  <= '0;
            err_q    <= access_err(in_size, in_addr[1:0]);
            state_q  <= access_err(in_size, in_addr[1:0]) ? StResp : StAccess;
          end
        end
        StAccess:  state_q <= we_q ? StResp : StCapture;
        StCapture: begin
          rdata_q <= fmt_ld_data;
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_ready[gnt_q]) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Mem is driven only from registered state; clr drops the strobes at once.
  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    mem_sel     = 4'b0000;
    mem_str     = 1'b0;
    mem_ld      = 1'b0;
    if (state_q == StAccess && !fmt_misalign) begin
      mem_addr    = addr_q[AW-1:2];
      mem_data_in = fmt_st_data;
      mem_sel     = fmt_sel;
      mem_str     = we_q;
      mem_ld      = ~we_q;
    end
  end

  assign rsp_valid = (state_q == StResp) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = (state_q == StResp) ? rdata_q : '0;
  assign rsp_err   = (state_q == StResp) && err_q;

endmodule
